// File: rtl/wb_pkg.sv
// Shared write-back control encoding, also used by control_unit.
package wb_pkg;

  localparam int WB_REG_WRITE_BIT  = 1;
  localparam int WB_MEM_TO_REG_BIT = 0;
  localparam int R0_ADDR           = 0;

  typedef logic [1:0] wb_control_t;

  function automatic logic wb_wants_write(input wb_control_t ctrl);
    return ctrl[WB_REG_WRITE_BIT];
  endfunction

  function automatic logic wb_from_mem(input wb_control_t ctrl);
    return ctrl[WB_MEM_TO_REG_BIT];
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Wrapping CNT_W-bit event counter with enable and async active-low reset.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/write_back.sv
// MEM/WB pipeline register, write-back mux and register-bank write port.
// Optional same-cycle decode bypass is enabled by defining WB_BYPASS_EN.
module write_back
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mem_valid,
  input  logic                  hold,
  input  wb_control_t           WB_control,
  input  logic [REG_ADDR_W-1:0] mem_rw,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [REG_ADDR_W-1:0] rw,
  output logic                  reg_write,
  output logic [DATA_W-1:0]     busw,
  output logic [CNT_W-1:0]      retired_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] rb,
  output logic                  fwd_a,
  output logic                  fwd_b
`endif
);

  logic valid_q;
  logic wr_req_q;
  logic written_q;
  logic capture;

  assign capture = ~hold;

  // A held instruction has already written on its first WB cycle, so
  // 'written' blocks any repeat until the next capture clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      wr_req_q  <= 1'b0;
      written_q <= 1'b0;
      rw        <= '0;
      busw      <= '0;
    end else if (capture) begin
      valid_q   <= mem_valid;
      wr_req_q  <= wb_wants_write(WB_control);
      written_q <= 1'b0;
      rw        <= mem_rw;
      busw      <= wb_from_mem(WB_control) ? mem_data : alu_result;
    end else begin
      written_q <= 1'b1;
    end
  end

  assign reg_write = valid_q & wr_req_q & (rw != REG_ADDR_W'(R0_ADDR)) & ~written_q;

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (capture & mem_valid),
    .count  (retired_count)
  );

`ifdef WB_BYPASS_EN
  assign fwd_a = reg_write & (ra == rw);
  assign fwd_b = reg_write & (rb == rw);
`endif

endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: the driver predicts each register-bank
// write from the MEM inputs, a monitor compares every cycle after the edge.
module tb_write_back;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 8;

  typedef struct {
    int                    cyc;
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     data;
  } exp_t;

  logic                  clock;
  logic                  reset_n;
  logic                  mem_valid;
  logic                  hold;
  logic [1:0]            WB_control;
  logic [REG_ADDR_W-1:0] mem_rw;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     mem_data;
  logic [REG_ADDR_W-1:0] rw;
  logic                  reg_write;
  logic [DATA_W-1:0]     busw;
  logic [CNT_W-1:0]      retired_count;
  logic [REG_ADDR_W-1:0] ra;
  logic [REG_ADDR_W-1:0] rb;
`ifdef WB_BYPASS_EN
  logic                  fwd_a;
  logic                  fwd_b;
`endif

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_count;
  int               cyc;
  int               checks;
  int               errors;

  write_back #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mem_valid    (mem_valid),
    .hold         (hold),
    .WB_control   (WB_control),
    .mem_rw       (mem_rw),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .rw           (rw),
    .reg_write    (reg_write),
    .busw         (busw),
    .retired_count(retired_count)
`ifdef WB_BYPASS_EN
    ,
    .ra           (ra),
    .rb           (rb),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of MEM-stage inputs and predict the retirement it causes.
  task automatic apply_stimulus(input logic v, input logic h, input logic [1:0] ctrl,
                                input logic [REG_ADDR_W-1:0] dst, input logic [DATA_W-1:0] alu,
                                input logic [DATA_W-1:0] mem, input logic [REG_ADDR_W-1:0] a,
                                input logic [REG_ADDR_W-1:0] b);
    exp_t e;
    @(negedge clock);
    mem_valid  = v;
    hold       = h;
    WB_control = ctrl;
    mem_rw     = dst;
    alu_result = alu;
    mem_data   = mem;
    ra         = a;
    rb         = b;
    if (reset_n && !h && v) begin
      exp_count = exp_count + 1'b1;
      if (ctrl[1] && dst != 0) begin
        e.cyc  = cyc + 1;
        e.rw   = dst;
        e.data = ctrl[0] ? mem : alu;
        sb.push_back(e);
      end
    end
  endtask

  task automatic bubble();
    apply_stimulus(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    mem_valid = 1'b0;
    hold      = 1'b0;
    reset_n   = 1'b0;
    sb.delete();
    exp_count = '0;
    #1;
    check_value("reset_reg_write", 64'(reg_write), 64'd0);
    check_value("reset_rw", 64'(rw), 64'd0);
    check_value("reset_busw", 64'(busw), 64'd0);
    check_value("reset_count", 64'(retired_count), 64'd0);
`ifdef WB_BYPASS_EN
    check_value("reset_fwd_a", 64'(fwd_a), 64'd0);
    check_value("reset_fwd_b", 64'(fwd_b), 64'd0);
`endif
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: one comparison set per clock, just after the capture edge.
  task automatic check_output();
    logic exp_wr;
    exp_t e;
    exp_wr = 1'b0;
    while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_wr = 1'b1;
      e = sb.pop_front();
    end
    check_value("reg_write", 64'(reg_write), 64'(exp_wr));
    check_value("retired_count", 64'(retired_count), 64'(exp_count));
    if (exp_wr && reg_write) begin
      check_value("rw", 64'(rw), 64'(e.rw));
      check_value("busw", 64'(busw), 64'(e.data));
    end
`ifdef WB_BYPASS_EN
    check_value("fwd_a", 64'(fwd_a), 64'(exp_wr && ra == e.rw));
    check_value("fwd_b", 64'(fwd_b), 64'(exp_wr && rb == e.rw));
`endif
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      check_output();
    end
  end

  initial begin
    logic [REG_ADDR_W-1:0] dst;
    checks     = 0;
    errors     = 0;
    exp_count  = '0;
    reset_n    = 1'b0;
    mem_valid  = 1'b0;
    hold       = 1'b0;
    WB_control = 2'b00;
    mem_rw     = '0;
    alu_result = '0;
    mem_data   = '0;
    ra         = '0;
    rb         = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    apply_stimulus(1'b1, 1'b0, 2'b10, 5'd7, 32'h0000_00AB, 32'h1111_1111, 5'd7, 5'd1);
    apply_stimulus(1'b1, 1'b0, 2'b11, 5'd3, 32'h2222_2222, 32'hDEAD_BEEF, 5'd2, 5'd3);
    apply_stimulus(1'b1, 1'b0, 2'b11, 5'd0, 32'h3333_3333, 32'hCAFE_F00D, 5'd0, 5'd0);
    bubble();

    apply_stimulus(1'b1, 1'b0, 2'b10, 5'd5, 32'h0000_0555, 32'h0, 5'd5, 5'd6);
    repeat (3) apply_stimulus(1'b1, 1'b1, 2'b10, 5'd6, 32'h0000_0666, 32'h0, 5'd5, 5'd6);
    bubble();
    apply_stimulus(1'b1, 1'b0, 2'b10, 5'd9, 32'h0000_0999, 32'h0, 5'd9, 5'd4);
    apply_stimulus(1'b1, 1'b0, 2'b01, 5'd9, 32'h0000_0AAA, 32'h0, 5'd9, 5'd4);
    apply_stimulus(1'b1, 1'b0, 2'b10, 5'd0, 32'h0000_0BBB, 32'h0, 5'd0, 5'd4);
    apply_stimulus(1'b1, 1'b0, 2'b10, 5'd12, 32'h0000_0C01, 32'h0, 5'd12, 5'd12);
    apply_stimulus(1'b1, 1'b0, 2'b10, 5'd12, 32'h0000_0C02, 32'h0, 5'd12, 5'd12);

    apply_stimulus(1'b1, 1'b0, 2'b10, 5'd14, 32'h0000_0E0E, 32'h0, 5'd14, 5'd1);
    apply_reset();
    repeat (3) bubble();

    for (int i = 0; i < 700; i++) begin
      dst = ($urandom_range(0, 5) == 0) ? '0 : REG_ADDR_W'($urandom);
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                     2'($urandom), dst, $urandom, $urandom,
                     ($urandom_range(0, 1) == 0) ? dst : REG_ADDR_W'($urandom),
                     ($urandom_range(0, 2) == 0) ? dst : REG_ADDR_W'($urandom));
      if (i == 350) apply_reset();
    end
    repeat (3) bubble();
    @(negedge clock);
    check_value("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
